// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder built around a single 4-bit carry-lookahead slice.
// Define NSA_SUBTRACT_EN to build the op=1 subtract path (b inverted, carry-in forced to 1).

module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] carry;

  // All carries are computed directly from generate/propagate, not rippled.
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry[0] = c_i;
    carry[1] = gen[0] | (prop[0] & c_i);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_i);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & c_i);
    co_o     = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & c_i);
    s_o      = prop ^ carry;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             co_q;
  logic [KW-1:0]    k_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0] aNib;
  logic [3:0] bNib;
  logic [3:0] sumNib;
  logic       coNib;
  logic       startCarry;
  logic       lastNib;

`ifdef NSA_SUBTRACT_EN
  logic op_q;

  always_comb begin
    bNib       = b_q[{k_q, 2'b00} +: 4] ^ {4{op_q}};
    startCarry = op ? 1'b1 : ci;
  end
`else
  logic unusedOp;

  assign unusedOp = op;

  always_comb begin
    bNib       = b_q[{k_q, 2'b00} +: 4];
    startCarry = ci;
  end
`endif

  always_comb begin
    aNib             = a_q[{k_q, 2'b00} +: 4];
    lastNib          = (k_q == KW'(N - 1));
    acc_d            = acc_q;
    acc_d[{k_q, 2'b00} +: 4] = sumNib;
  end

  cla4 u_cla4 (
    .a_i (aNib),
    .b_i (bNib),
    .c_i (c_q),
    .s_o (sumNib),
    .co_o(coNib)
  );

  // Result and handshake outputs are registered; s/co only move on the final nibble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      k_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NSA_SUBTRACT_EN
      op_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            a_q     <= a;
            b_q     <= b;
            c_q     <= startCarry;
            k_q     <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef NSA_SUBTRACT_EN
            op_q    <= op;
`endif
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          c_q   <= coNib;
          if (lastNib) begin
            state_q <= DONE;
            s_q     <= acc_d;
            co_q    <= coNib;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign co    = co_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random operations
// against a cycle-count reference model; honours NSA_SUBTRACT_EN like the design.

module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             ci    = 1'b0;
  logic             op    = 1'b0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  int vectors    = 0;
  int miscompares = 0;
  bit running    = 1'b1;

  logic             mBusy = 1'b0;
  logic             mDone = 1'b0;
  logic [WIDTH-1:0] mS    = '0;
  logic             mCo   = 1'b0;
  logic [WIDTH:0]   mPend = '0;
  int               mCnt  = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .op   (op),
    .ready(ready),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                               input logic civ, input logic opv);
`ifdef NSA_SUBTRACT_EN
    if (opv) return {1'b0, av} + {1'b0, ~bv} + (WIDTH+1)'(1);
`else
    if (opv) return {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(civ);
`endif
    return {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(civ);
  endfunction

  // Reference: an accepted request completes N edges later with the full-width sum.
  always @(posedge clk) begin
    if (reset) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mCnt  <= 0;
      mS    <= '0;
      mCo   <= 1'b0;
    end else if (!mBusy && start) begin
      mPend <= refResult(a, b, ci, op);
      mBusy <= 1'b1;
      mCnt  <= N;
      mDone <= 1'b0;
    end else if (mBusy) begin
      if (mCnt == 1) begin
        mBusy <= 1'b0;
        mDone <= 1'b1;
        mS    <= mPend[WIDTH-1:0];
        mCo   <= mPend[WIDTH];
      end
      mCnt <= mCnt - 1;
    end else begin
      mDone <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic civ, input logic opv);
    @(negedge clk);
    a     = av;
    b     = bv;
    ci    = civ;
    op    = opv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    ci    = 1'($urandom);
    op    = 1'($urandom);
  endtask

  task automatic waitDone(input string name, input int bound, output int cycles);
    cycles = 0;
    while (!done && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) checkOutput({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic countDones(input int span, output int pulses);
    pulses = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int cycles;
    int pulses;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    fork
      forever begin
        @(negedge clk);
        if (running) begin
          checkOutput("ready", 32'(ready), 32'(!mBusy));
          checkOutput("busy",  32'(busy),  32'(mBusy));
          checkOutput("done",  32'(done),  32'(mDone));
          checkOutput("s",     32'(s),     32'(mS));
          checkOutput("co",    32'(co),    32'(mCo));
        end
      end
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset busy",  32'(busy),  32'd0);
    checkOutput("reset s",     32'(s),     32'd0);
    reset = 1'b0;

    // Full carry ripple across every nibble.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitDone("ripple", 20, cycles);
    checkOutput("ripple latency", 32'(cycles), 32'(N));
    checkOutput("ripple s",  32'(s),  32'h0000);
    checkOutput("ripple co", 32'(co), 32'd1);
    @(negedge clk);
    checkOutput("ripple ready after", 32'(ready), 32'd1);
    checkOutput("ripple s held",      32'(s),     32'h0000);

    // Carry-in; previous result must persist during RUN.
    applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
    checkOutput("cin s during run", 32'(s), 32'h0000);
    waitDone("cin", 20, cycles);
    checkOutput("cin s",  32'(s),  32'h5556);
    checkOutput("cin co", 32'(co), 32'd0);

    // Start while busy is ignored.
    applyStimulus(16'h00F0, 16'h0010, 1'b0, 1'b0);
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("busy start", 20, cycles);
    checkOutput("busy start s",  32'(s),  32'h0100);
    checkOutput("busy start co", 32'(co), 32'd0);
    countDones(10, pulses);
    checkOutput("busy start extra done", 32'(pulses), 32'd0);

    // Back-to-back: start held through the DONE cycle.
    applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0);
    waitDone("b2b first", 20, cycles);
    a = 16'h8000; b = 16'h8000; ci = 1'b0; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b no bubble", 32'(busy), 32'd1);
    waitDone("b2b second", 20, cycles);
    checkOutput("b2b spacing", 32'(cycles + 1), 32'(N + 1));
    checkOutput("b2b s",  32'(s),  32'h0000);
    checkOutput("b2b co", 32'(co), 32'd1);

    // Reset on the second RUN cycle aborts.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy",  32'(busy),  32'd0);
    checkOutput("abort ready", 32'(ready), 32'd1);
    checkOutput("abort s",     32'(s),     32'h0000);
    checkOutput("abort co",    32'(co),    32'd0);
    countDones(10, pulses);
    checkOutput("abort no done", 32'(pulses), 32'd0);

    // Subtract request (add when the feature is not built).
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    waitDone("sub1", 20, cycles);
`ifdef NSA_SUBTRACT_EN
    checkOutput("sub1 s",  32'(s),  32'hFFFE);
    checkOutput("sub1 co", 32'(co), 32'd0);
    applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1);
    waitDone("sub2", 20, cycles);
    checkOutput("sub2 s",  32'(s),  32'h0002);
    checkOutput("sub2 co", 32'(co), 32'd1);
`else
    checkOutput("sub1 s",  32'(s),  32'h000C);
    checkOutput("sub1 co", 32'(co), 32'd0);
`endif

    // Random operations with random gaps, stray starts and occasional aborts.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 10 == 0) rb = ~ra;
      applyStimulus(ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        waitDone("random", 20, cycles);
      end
    end

    repeat (3) @(negedge clk);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
